// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 target that turns MCU frames into accesses on the
// internal 32-bit register bus. A frame is one command byte followed by any
// number of 32-bit data words, and the address auto-increments for bursts.
// The SPI pins are oversampled through synchronisers into the clk domain.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [5:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wstrobe,
  input  logic [31:0] reg_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_dly_q, sck_dly_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  cmd_q, cmd_d;
  logic [30:0] rx_q, rx_d;
  logic [30:0] tx_q, tx_d;
  logic        dir_q, dir_d;
  logic        load_q, load_d;
  logic        armed_q, armed_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wstrobe_q, wstrobe_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;

  // Next values for the input synchronisers and the SCK edge-detect delay flop.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_dly_d   = sck_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser chains; SCK has one extra stage so rise/fall can be seen as events.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;

  // Frame decoder: command byte, then data words; a chip-select release always wins.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    dir_d     = dir_q;
    load_d    = load_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrobe_d = 1'b0;
    miso_d    = miso_q;
    // The bridge only arms after seeing cs_n high, so a reset mid-frame waits for a fresh frame.
    armed_d   = armed_q | cs_s;
    oe_d      = armed_q & ~cs_s;

    // A write strobe is followed by the burst address step in the next cycle.
    if (wstrobe_q) begin
      addr_d = addr_q + 6'd4;
    end

    if (cs_s) begin
      miso_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = 5'd0;
        if (armed_q && !cs_s) begin
          state_d = CMD;
        end
      end

      CMD: begin
        if (cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = 5'd0;
        end else if (sck_rise) begin
          cmd_d     = {cmd_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            addr_d    = {cmd_q[4:1], 2'b00};
            dir_d     = cmd_q[6];
            state_d   = DATA;
            bit_cnt_d = 5'd0;
            load_d    = 1'b1;
          end
        end
      end

      DATA: begin
        if (cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = 5'd0;
        end else if (sck_rise) begin
          rx_d      = {rx_q[29:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            bit_cnt_d = 5'd0;
            if (dir_q) begin
              wdata_d   = {rx_q, mosi_s};
              wstrobe_d = 1'b1;
            end else begin
              addr_d = addr_q + 6'd4;
              load_d = 1'b1;
            end
          end
        end else if (sck_fall && !dir_q) begin
          if (load_q) begin
            tx_d   = reg_rdata[30:0];
            miso_d = reg_rdata[31];
            load_d = 1'b0;
          end else begin
            tx_d   = {tx_q[29:0], 1'b0};
            miso_d = tx_q[30];
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = 5'd0;
      end
    endcase
  end

  // Frame state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 5'd0;
      cmd_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      dir_q     <= 1'b0;
      load_q    <= 1'b0;
      armed_q   <= 1'b0;
      addr_q    <= 6'd0;
      wdata_q   <= 32'd0;
      wstrobe_q <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      dir_q     <= dir_d;
      load_q    <= load_d;
      armed_q   <= armed_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrobe_q <= wstrobe_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
    end
  end

  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wstrobe = wstrobe_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: drives SPI frames from a table of command/data vectors,
// models the register file read data, and scoreboards write strobes and MISO words.
`timescale 1ns/1ps
module tb_spi_reg_bridge;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wstrobe;
  logic [31:0] reg_rdata;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd;
    int          nwords;
    logic [31:0] word [3];
    logic [5:0]  waddr [3];
    logic [5:0]  final_addr;
  } vec_t;

  wr_t         wr_q [$];
  logic [31:0] rd_q [$];
  vec_t        vecs [$];
  logic        prev_strobe;

  spi_reg_bridge #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wstrobe (reg_wstrobe),
    .reg_rdata   (reg_rdata)
  );

  always #5 clk = ~clk;

  // Register file model: read data is an address-dependent pattern.
  assign reg_rdata = 32'hA500_0000 | {26'd0, reg_addr};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (reg_wstrobe) begin
        if (prev_strobe) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL strobe_back_to_back: strobe high two cycles at addr 0x%02h", reg_addr);
        end
        if (wr_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_strobe: addr 0x%02h data 0x%08h, expected no strobe", reg_addr, reg_wdata);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          checkOutput("strobe_addr", {26'd0, reg_addr}, {26'd0, e.addr});
          checkOutput("strobe_data", reg_wdata, e.data);
        end
      end
      prev_strobe = reg_wstrobe;
    end
  end

  task automatic spi_bits(input logic [31:0] w, input int nbits, output logic [31:0] r);
    r = 32'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = w[31-i];
      repeat (HALF) @(negedge clk);
      r = {r[30:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input int n,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                              input logic [5:0] fin);
    vec_t v;
    v.cmd = cmd;
    v.nwords = n;
    v.word[0] = w0;
    v.word[1] = w1;
    v.word[2] = w2;
    v.waddr[0] = a0;
    v.waddr[1] = a1;
    v.waddr[2] = a2;
    v.final_addr = fin;
    return v;
  endfunction

  // One complete frame: write words are pushed to the write scoreboard, read words to the MISO one.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] r;
    logic [31:0] e;
    cs_low();
    checkOutput("oe_active", {31'd0, spi_miso_oe}, 32'd1);
    spi_bits({v.cmd, 24'd0}, 8, r);
    for (int i = 0; i < v.nwords; i++) begin
      if (v.cmd[7]) begin
        wr_q.push_back('{addr: v.waddr[i], data: v.word[i]});
        spi_bits(v.word[i], 32, r);
      end else begin
        rd_q.push_back(v.word[i]);
        spi_bits(32'd0, 32, r);
        e = rd_q.pop_front();
        checkOutput("miso_word", r, e);
      end
    end
    cs_high();
    checkOutput("final_addr", {26'd0, reg_addr}, {26'd0, v.final_addr});
    checkOutput("oe_idle", {31'd0, spi_miso_oe}, 32'd0);
    checkOutput("miso_idle", {31'd0, spi_miso}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;

    vecs.push_back(mk(8'h88, 1, 32'h8000_0280, 32'h0, 32'h0, 6'h08, 6'h00, 6'h00, 6'h0C));
    vecs.push_back(mk(8'h24, 1, 32'hA500_0024, 32'h0, 32'h0, 6'h00, 6'h00, 6'h00, 6'h28));
    vecs.push_back(mk(8'hBC, 3, 32'hDEAD_BEEF, 32'h0123_4567, 32'hCAFE_F00D, 6'h3C, 6'h00, 6'h04, 6'h08));
    vecs.push_back(mk(8'h38, 2, 32'hA500_0038, 32'hA500_003C, 32'h0, 6'h00, 6'h00, 6'h00, 6'h00));
    vecs.push_back(mk(8'h07, 1, 32'hA500_0004, 32'h0, 32'h0, 6'h00, 6'h00, 6'h00, 6'h08));
    vecs.push_back(mk(8'hC3, 1, 32'h5A5A_A5A5, 32'h0, 32'h0, 6'h00, 6'h00, 6'h00, 6'h04));
    vecs.push_back(mk(8'h50, 1, 32'hA500_0010, 32'h0, 32'h0, 6'h00, 6'h00, 6'h00, 6'h14));

    reset    = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_addr", {26'd0, reg_addr}, 32'd0);
    checkOutput("rst_wdata", reg_wdata, 32'd0);
    checkOutput("rst_strobe", {31'd0, reg_wstrobe}, 32'd0);
    checkOutput("rst_miso", {31'd0, spi_miso}, 32'd0);
    checkOutput("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Aborted write word: no strobe, address stays at the command value.
    cs_low();
    spi_bits(32'h8000_0000, 8, r);
    spi_bits(32'hFFFF_FFFF, 20, r);
    cs_high();
    checkOutput("abort_addr", {26'd0, reg_addr}, 32'h00);

    // Partial command byte: address unchanged.
    cs_low();
    spi_bits(32'hBC00_0000, 5, r);
    cs_high();
    checkOutput("partial_cmd_addr", {26'd0, reg_addr}, 32'h00);

    applyStimulus(mk(8'h84, 1, 32'h1234_5678, 32'h0, 32'h0, 6'h04, 6'h00, 6'h00, 6'h08));

    // Reset in the middle of a write word, then clock out the rest of the frame.
    cs_low();
    spi_bits(32'h9000_0000, 8, r);
    spi_bits(32'hFFFF_FFFF, 12, r);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_addr", {26'd0, reg_addr}, 32'd0);
    checkOutput("midrst_wdata", reg_wdata, 32'd0);
    checkOutput("midrst_strobe", {31'd0, reg_wstrobe}, 32'd0);
    checkOutput("midrst_miso", {31'd0, spi_miso}, 32'd0);
    checkOutput("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    reset = 1'b0;
    spi_bits(32'hFFFF_FFFF, 20, r);
    spi_bits(32'hA5A5_5A5A, 32, r);
    checkOutput("midrst_oe_held", {31'd0, spi_miso_oe}, 32'd0);
    cs_high();
    checkOutput("midrst_after_addr", {26'd0, reg_addr}, 32'd0);

    applyStimulus(mk(8'h94, 1, 32'hFEED_C0DE, 32'h0, 32'h0, 6'h14, 6'h00, 6'h00, 6'h18));

    repeat (10) @(negedge clk);
    checkOutput("wr_queue_drained", wr_q.size(), 32'd0);
    checkOutput("rd_queue_drained", rd_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI target that turns MCU SPI frames into accesses on the internal 32-bit register bus (reg_addr/reg_wdata/reg_wstrobe/reg_rdata) used by the video config block and its siblings.
- It is the initiator end of that register interface. The SPI pins are oversampled and synchronised into the single system clock domain.
- Supports single and auto-incrementing burst reads and writes.

Parameters:
- SYNC_STAGES, 2, number of flops in each SPI input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- spi_sck  input  1  SPI clock, mode 0, asynchronous to clk
- spi_cs_n  input  1  SPI chip select, active low, asynchronous
- spi_mosi  input  1  SPI data in, asynchronous
- spi_miso  output  1  SPI data out
- spi_miso_oe  output  1  output enable for spi_miso pad; high while frame active
- reg_addr  output  6  register byte address; bits 1:0 always 0
- reg_wdata  output  32  register write data
- reg_wstrobe  output  1  one-cycle write pulse
- reg_rdata  input  32  register read data; combinational function of reg_addr

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values: reg_addr=0, reg_wdata=0, reg_wstrobe=0, spi_miso=0, spi_miso_oe=0, state=IDLE, bit counter=0, shift registers=0.
- Synchronisation:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops.
  - Rise and fall events are detected from the last stage and one extra delay flop.
  - Event latency is SYNC_STAGES+1 clk.
  - Constraint: SCK high and low times each ≥4 clk; cs_n setup to first SCK rise ≥4 clk.
- Frame format, mode 0, MSB first:
  - MOSI sampled on rise events; MISO updated on fall events.
  - Byte 0 is the command: [7]=1 write / 0 read, [6] ignored, [5:0] start address (bits 1:0 forced to 0 on load).
  - Followed by any number of 32-bit data words.
- FSM:
  - IDLE: wait for synced cs_n=0, then go to CMD with bit count cleared. spi_miso_oe=1 whenever synced cs_n=0.
  - CMD: shift MOSI on each rise. On the 8th rise, load reg_addr={cmd[5:2],2'b00}, latch the dir flag, go to DATA, bit count=0.
  - DATA write:
    - Shift MOSI into a 32-bit register on each rise.
    - On the 32nd rise, reg_wdata takes the assembled word in the same cycle and reg_wstrobe is high for exactly the following cycle.
    - reg_addr increments by 4 in the cycle after the strobe (6-bit wrap: 0x3C→0x00). Bit count resets.
  - DATA read:
    - On the first fall event after entering DATA, the tx shift register loads reg_rdata and spi_miso=bit31.
    - Each later fall shifts left (spi_miso=next bit).
    - On the 32nd rise, reg_addr increments by 4 (wrap as above). The next fall loads reg_rdata for the new address.
    - Writes never occur in a read frame.
- Synced cs_n rising in any state: return to IDLE in the next cycle; spi_miso_oe=0; spi_miso=0.
  - A partial data word is discarded (no strobe).
  - A partial command byte causes no address change.
- A strobe already issued is not retracted.
- cs_n rise and SCK event in the same cycle: cs_n wins and the SCK event is ignored.
- Reset mid-frame: immediate return to reset values. The bridge then waits for cs_n to go high and low again before accepting a command, so no mid-frame resync.
- Invariant: reg_wstrobe is never asserted for two consecutive cycles.

Test Plan:
- Single write: cmd 0x88, data 0x8000_0280 → one reg_wstrobe pulse with reg_addr=0x08, reg_wdata=0x8000_0280; reg_addr=0x0C afterwards. No other strobes.
- Single read: model reg_rdata=addr-dependent pattern (0xA5000000|addr); cmd 0x24, clock 32 bits → MISO returns 0xA5000024 MSB first; no reg_wstrobe.
- Burst write with wrap: cmd 0xBC, three words W0..W2 → strobes at reg_addr 0x3C, 0x00, 0x04 with matching data.
- Burst read: cmd 0x38, 64 data clocks → MISO returns 0xA5000038 then 0xA500003C.
- Abort: cmd 0x80 then 20 data bits, raise cs_n → no strobe. The next frame (cmd 0x84, word 0x1234_5678) strobes at 0x04 with 0x1234_5678.
- Reset mid-frame: assert reset during bit 12 of a write word → all outputs at reset values. The remainder of that frame produces no strobe; the following clean frame works normally.
